// File: rtl/store_buffer_ctrl_if.sv
// Bus bundle between the dual-issue pipeline / data memory and the store buffer
// controller. The master side drives allocations, commits, flush and the
// memory acknowledge; the slave side (the controller) drives the memory request
// and the registered status flags.
interface store_buffer_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          alloc_en1;
  logic [AW-1:0] alloc_addr1;
  logic [DW-1:0] alloc_data1;
  logic          alloc_en2;
  logic [AW-1:0] alloc_addr2;
  logic [DW-1:0] alloc_data2;
  logic          write1;
  logic          write2;
  logic          flush;
  logic          mem_ack;
  logic          alloc_ready;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          sb_empty;

  modport master (
    output alloc_en1, alloc_addr1, alloc_data1,
    output alloc_en2, alloc_addr2, alloc_data2,
    output write1, write2, flush, mem_ack,
    input  alloc_ready, mem_req, mem_addr, mem_data, sb_empty
  );

  modport slave (
    input  alloc_en1, alloc_addr1, alloc_data1,
    input  alloc_en2, alloc_addr2, alloc_data2,
    input  write1, write2, flush, mem_ack,
    output alloc_ready, mem_req, mem_addr, mem_data, sb_empty
  );
endinterface

// File: rtl/store_buffer_ctrl.sv
// In-order store buffer controller. Entries live in a circular array tracked
// by three wrap-bit pointers: head (oldest, next to drain), cptr (first
// uncommitted) and tail (next free). Stores are allocated speculatively,
// committed in order, discarded on flush if still uncommitted, and drained to
// memory one at a time over a req/ack handshake.
module store_buffer_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input logic              clk,
  input logic              rst,
  store_buffer_ctrl_if.slave sb
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] TWO_P   = PW'(2);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  logic [AW-1:0] entry_addr_q [DEPTH];
  logic [DW-1:0] entry_data_q [DEPTH];

  state_t        state_q, state_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] cptr_q, cptr_d;
  logic [PW-1:0] tail_q, tail_d;
  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_data_q, mem_data_d;
  logic          alloc_ready_q, alloc_ready_d;
  logic          sb_empty_q, sb_empty_d;

  logic [PW-1:0] uncommitted;
  logic [PW-1:0] commit_req;
  logic [PW-1:0] commit_adv;
  logic [PW-1:0] occupancy;
  logic [PW-1:0] free_slots;
  logic [PW-1:0] next_occ;
  logic          wr0_en, wr1_en;
  logic [IW-1:0] wr0_idx, wr1_idx;
  logic [AW-1:0] wr0_addr;
  logic [DW-1:0] wr0_data;

  // Commit, flush and allocation: everything is judged against start-of-cycle
  // pointers, so a drain finishing this cycle never frees a slot for an alloc.
  always_comb begin
    uncommitted = tail_q - cptr_q;
    commit_req  = PW'(sb.write1) + PW'(sb.write2);
    commit_adv  = (commit_req > uncommitted) ? uncommitted : commit_req;
    cptr_d      = cptr_q + commit_adv;
    occupancy   = tail_q - head_q;
    free_slots  = DEPTH_P - occupancy;
    wr0_en      = 1'b0;
    wr1_en      = 1'b0;
    wr0_idx     = tail_q[IW-1:0];
    wr1_idx     = tail_q[IW-1:0] + IW'(1);
    wr0_addr    = sb.alloc_addr1;
    wr0_data    = sb.alloc_data1;
    tail_d      = tail_q;
    if (sb.flush) begin
      tail_d = cptr_d;
    end else begin
      if ((sb.alloc_en1 || sb.alloc_en2) && (free_slots != '0)) begin
        wr0_en = 1'b1;
        if (!sb.alloc_en1) begin
          wr0_addr = sb.alloc_addr2;
          wr0_data = sb.alloc_data2;
        end
      end
      if (sb.alloc_en1 && sb.alloc_en2 && (free_slots >= TWO_P)) begin
        wr1_en = 1'b1;
      end
      tail_d = tail_q + PW'(wr0_en) + PW'(wr1_en);
    end
  end

  // Drain FSM: pick up the head entry once it is committed, hold it until ack,
  // then return to IDLE for one bubble cycle before looking again.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    case (state_q)
      S_IDLE: begin
        if (cptr_q != head_q) begin
          mem_addr_d = entry_addr_q[head_q[IW-1:0]];
          mem_data_d = entry_data_q[head_q[IW-1:0]];
          mem_req_d  = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (sb.mem_ack) begin
          head_d    = head_q + PW'(1);
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // Status flags are computed from the next-state pointers so they are valid
  // in the cycle right after the edge that changed occupancy.
  always_comb begin
    next_occ      = tail_d - head_d;
    alloc_ready_d = ((DEPTH_P - next_occ) >= TWO_P);
    sb_empty_d    = (tail_d == head_d);
  end

  // Entry storage needs no reset; only slots behind tail are ever read.
  always_ff @(posedge clk) begin
    if (wr0_en) begin
      entry_addr_q[wr0_idx] <= wr0_addr;
      entry_data_q[wr0_idx] <= wr0_data;
    end
    if (wr1_en) begin
      entry_addr_q[wr1_idx] <= sb.alloc_addr2;
      entry_data_q[wr1_idx] <= sb.alloc_data2;
    end
  end

  // Pointer, FSM and registered output state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      head_q        <= '0;
      cptr_q        <= '0;
      tail_q        <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      alloc_ready_q <= 1'b1;
      sb_empty_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      cptr_q        <= cptr_d;
      tail_q        <= tail_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      alloc_ready_q <= alloc_ready_d;
      sb_empty_q    <= sb_empty_d;
    end
  end

  assign sb.alloc_ready = alloc_ready_q;
  assign sb.mem_req     = mem_req_q;
  assign sb.mem_addr    = mem_addr_q;
  assign sb.mem_data    = mem_data_q;
  assign sb.sb_empty    = sb_empty_q;

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Directed testbench for store_buffer_ctrl (DEPTH=8): basic drain timing,
// flush with same-cycle commit, full/wrap-around, held request, over-commit
// and reset during a handshake.
module tb_store_buffer_ctrl;

  logic clk;
  logic rst;
  int   assert_cnt;
  int   fail_cnt;

  store_buffer_ctrl_if #(.AW(32), .DW(32)) sb_if ();

  store_buffer_ctrl #(.DEPTH(8), .AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(
    input logic        a1,
    input logic [31:0] ad1,
    input logic [31:0] dt1,
    input logic        a2,
    input logic [31:0] ad2,
    input logic [31:0] dt2,
    input logic        w1,
    input logic        w2,
    input logic        fl
  );
    sb_if.alloc_en1   = a1;
    sb_if.alloc_addr1 = ad1;
    sb_if.alloc_data1 = dt1;
    sb_if.alloc_en2   = a2;
    sb_if.alloc_addr2 = ad2;
    sb_if.alloc_data2 = dt2;
    sb_if.write1      = w1;
    sb_if.write2      = w2;
    sb_if.flush       = fl;
    step();
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assert_cnt++;
    assert (observed === expected) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    sb_if.mem_ack = 1'b0;
    rst = 1'b1;
    idleCycle();
    idleCycle();
    rst = 1'b0;
  endtask

  // Hold ack high and check that `count` consecutive stores drain in order.
  task automatic expectDrain(input int count, input logic [31:0] addr0, input logic [31:0] data0, input string tag);
    int k = 0;
    sb_if.mem_ack = 1'b1;
    for (int c = 0; (c < 4 * count + 10) && (k < count); c++) begin
      if (sb_if.mem_req === 1'b1) begin
        checkOutput({tag, "_addr"}, sb_if.mem_addr, addr0 + 32'(4 * k));
        checkOutput({tag, "_data"}, sb_if.mem_data, data0 + 32'(k));
        k++;
      end
      step();
    end
    sb_if.mem_ack = 1'b0;
    checkOutput({tag, "_count"}, 64'(k), 64'(count));
  endtask

  initial begin
    clk        = 1'b0;
    rst        = 1'b1;
    assert_cnt = 0;
    fail_cnt   = 0;
    sb_if.mem_ack = 1'b0;

    // Reset state
    doReset();
    checkOutput("rst_req", sb_if.mem_req, 0);
    checkOutput("rst_addr", sb_if.mem_addr, 0);
    checkOutput("rst_data", sb_if.mem_data, 0);
    checkOutput("rst_empty", sb_if.sb_empty, 1);
    checkOutput("rst_ready", sb_if.alloc_ready, 1);
    checkOutput("rst_tail", dut.tail_q, 0);

    // Basic drain: dual alloc, dual commit, ack held high
    $display("[TB] basic drain");
    applyStimulus(1'b1, 32'h100, 32'hAA, 1'b1, 32'h104, 32'hBB, 1'b0, 1'b0, 1'b0);
    sb_if.mem_ack = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    checkOutput("bd_c2_req", sb_if.mem_req, 0);
    checkOutput("bd_c2_empty", sb_if.sb_empty, 0);
    idleCycle();
    checkOutput("bd_c3_req", sb_if.mem_req, 1);
    checkOutput("bd_c3_addr", sb_if.mem_addr, 32'h100);
    checkOutput("bd_c3_data", sb_if.mem_data, 32'hAA);
    idleCycle();
    checkOutput("bd_c4_bubble", sb_if.mem_req, 0);
    idleCycle();
    checkOutput("bd_c5_req", sb_if.mem_req, 1);
    checkOutput("bd_c5_addr", sb_if.mem_addr, 32'h104);
    checkOutput("bd_c5_data", sb_if.mem_data, 32'hBB);
    idleCycle();
    checkOutput("bd_c6_req", sb_if.mem_req, 0);
    checkOutput("bd_c6_empty", sb_if.sb_empty, 1);
    sb_if.mem_ack = 1'b0;

    // Flush in the same cycle as committing the second store
    $display("[TB] flush");
    doReset();
    applyStimulus(1'b1, 32'h200, 32'h11, 1'b1, 32'h204, 32'h22, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h208, 32'h33, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h20C, 32'h44, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    checkOutput("fl_tail", dut.tail_q, 2);
    checkOutput("fl_cptr", dut.cptr_q, 2);
    checkOutput("fl_req0", sb_if.mem_req, 1);
    checkOutput("fl_addr0", sb_if.mem_addr, 32'h200);
    checkOutput("fl_data0", sb_if.mem_data, 32'h11);
    sb_if.mem_ack = 1'b1;
    idleCycle();
    checkOutput("fl_bubble", sb_if.mem_req, 0);
    idleCycle();
    checkOutput("fl_req1", sb_if.mem_req, 1);
    checkOutput("fl_addr1", sb_if.mem_addr, 32'h204);
    checkOutput("fl_data1", sb_if.mem_data, 32'h22);
    idleCycle();
    checkOutput("fl_done_req", sb_if.mem_req, 0);
    checkOutput("fl_empty", sb_if.sb_empty, 1);
    idleCycle();
    checkOutput("fl_no_third", sb_if.mem_req, 0);
    checkOutput("fl_head", dut.head_q, 2);
    sb_if.mem_ack = 1'b0;

    // Fill to full, reject a ninth store, drain, then allocate across the wrap
    $display("[TB] full and wrap-around");
    doReset();
    applyStimulus(1'b1, 32'h300, 32'hD0, 1'b1, 32'h304, 32'hD1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h308, 32'hD2, 1'b1, 32'h30C, 32'hD3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h310, 32'hD4, 1'b1, 32'h314, 32'hD5, 1'b0, 1'b0, 1'b0);
    checkOutput("full_occ6_ready", sb_if.alloc_ready, 1);
    applyStimulus(1'b1, 32'h318, 32'hD6, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("full_occ7_ready", sb_if.alloc_ready, 0);
    applyStimulus(1'b0, '0, '0, 1'b1, 32'h31C, 32'hD7, 1'b0, 1'b0, 1'b0);
    checkOutput("full_occ8_ready", sb_if.alloc_ready, 0);
    applyStimulus(1'b1, 32'h3F0, 32'hEE, 1'b1, 32'h3F4, 32'hEF, 1'b0, 1'b0, 1'b0);
    checkOutput("full_ninth_dropped", dut.tail_q, 8);
    checkOutput("full_not_empty", sb_if.sb_empty, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    end
    idleCycle();
    checkOutput("full_cptr", dut.cptr_q, 8);
    expectDrain(8, 32'h300, 32'hD0, "full_drain");
    checkOutput("full_drained_empty", sb_if.sb_empty, 1);
    checkOutput("full_head", dut.head_q, 8);
    applyStimulus(1'b1, 32'h400, 32'hE0, 1'b1, 32'h404, 32'hE1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h408, 32'hE2, 1'b1, 32'h40C, 32'hE3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    expectDrain(4, 32'h400, 32'hE0, "wrap_drain");
    checkOutput("wrap_head", dut.head_q, 12);
    checkOutput("wrap_empty", sb_if.sb_empty, 1);

    // Request held stable while ack stays low
    $display("[TB] held request");
    doReset();
    applyStimulus(1'b1, 32'h500, 32'h55, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    idleCycle();
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_req", sb_if.mem_req, 1);
      checkOutput("hold_addr", sb_if.mem_addr, 32'h500);
      checkOutput("hold_data", sb_if.mem_data, 32'h55);
      checkOutput("hold_head", dut.head_q, 0);
      idleCycle();
    end
    sb_if.mem_ack = 1'b1;
    idleCycle();
    sb_if.mem_ack = 1'b0;
    checkOutput("hold_after_req", sb_if.mem_req, 0);
    checkOutput("hold_after_head", dut.head_q, 1);

    // Over-commit: two commit slots with one uncommitted entry
    $display("[TB] over-commit");
    doReset();
    applyStimulus(1'b1, 32'h600, 32'h66, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    checkOutput("oc_cptr", dut.cptr_q, 1);
    applyStimulus(1'b1, 32'h604, 32'h67, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("oc_cptr2", dut.cptr_q, 2);
    expectDrain(2, 32'h600, 32'h66, "oc_drain");
    checkOutput("oc_empty", sb_if.sb_empty, 1);

    // Reset while a request is outstanding
    $display("[TB] reset mid-handshake");
    doReset();
    applyStimulus(1'b1, 32'h700, 32'h77, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    idleCycle();
    checkOutput("mr_req_before", sb_if.mem_req, 1);
    rst = 1'b1;
    idleCycle();
    rst = 1'b0;
    checkOutput("mr_req", sb_if.mem_req, 0);
    checkOutput("mr_empty", sb_if.sb_empty, 1);
    checkOutput("mr_ready", sb_if.alloc_ready, 1);
    sb_if.mem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idleCycle();
      checkOutput("mr_quiet", sb_if.mem_req, 0);
    end
    sb_if.mem_ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
